// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
//   state_t        : converter FSM states (IDLE, SHIFT, DONE)
//   DIGIT_W        : bits per BCD digit
//   ADJ_THRESH     : digit value at or above which the +3 correction applies
//   min_digits()   : decimal digits needed to hold 2^bin_w - 1
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] ADJ_THRESH = 4'd5;

  // Counts the decimal digits of the largest BIN_W-bit unsigned value.
  function automatic int min_digits(input int bin_w);
    longint unsigned max_val;
    int n;
    max_val = (64'd1 << bin_w) - 64'd1;
    n = 1;
    for (int i = 0; i < 20; i++) begin
      if (max_val >= 64'd10) begin
        max_val = max_val / 64'd10;
        n++;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/bin2bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more,
// so that the following left shift carries correctly into the next digit.
//   digit : current 4-bit accumulator digit
//   adj   : corrected digit (4-bit wrap, no carry out)
module bin2bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [DIGIT_W-1:0] adj
);

  always_comb begin
    // NOTE: default assignment first so every path drives adj and no latch is inferred.
    adj = digit;
    if (digit >= ADJ_THRESH) adj = digit + 4'd3;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Multi-cycle binary-to-BCD converter (shift-add-3, one bit per enabled cycle).
//   clk, rst      : clock and synchronous active-high reset
//   en            : global enable; low freezes all state and forces in_ready low
//   in_valid/in_ready/binary : input handshake and BIN_W-bit value
//   out_valid/out_ready/bcd  : result handshake and packed BCD (digit 0 in [3:0])
//   busy          : high while a conversion is shifting
//   sign          : result sign, only when BIN2BCD_SIGNED_EN is defined
// Optional feature macro: BIN2BCD_SIGNED_EN (two's complement input, sign port).
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BIN_W-1:0]          binary,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIGIT_W*DIGITS-1:0] bcd,
  output logic                      busy
`ifdef BIN2BCD_SIGNED_EN
  ,
  output logic                      sign
`endif
);

  localparam int ACC_W = DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  if (BIN_W < 4 || BIN_W > 32) begin : g_bad_bin_w
    $fatal(1, "bin2bcd_seq: BIN_W=%0d outside 4..32", BIN_W);
  end
  if (DIGITS < min_digits(BIN_W)) begin : g_bad_digits
    $fatal(1, "bin2bcd_seq: DIGITS=%0d too small for BIN_W=%0d", DIGITS, BIN_W);
  end

  state_t                 state;
  logic [BIN_W-1:0]       sreg;
  logic [ACC_W-1:0]       acc;
  logic [ACC_W-1:0]       acc_adj;
  logic [CNT_W-1:0]       cnt;
  logic [ACC_W+BIN_W-1:0] shifted;
  logic [BIN_W-1:0]       load_val;

  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    bin2bcd_digit_adj u_adj (
      .digit (acc[d*DIGIT_W +: DIGIT_W]),
      .adj   (acc_adj[d*DIGIT_W +: DIGIT_W])
    );
  end

  // The top accumulator bit falls off the end; it is always 0 because
  // DIGITS is large enough for the full input range.
  assign shifted  = {acc_adj, sreg} << 1;
  assign in_ready = en && (state == IDLE);
  assign busy     = (state == SHIFT);

`ifdef BIN2BCD_SIGNED_EN
  logic load_sign;
  logic sign_q;
  assign load_sign = binary[BIN_W-1];
  // Unsigned reading of the negation also covers -2^(BIN_W-1) -> 2^(BIN_W-1).
  assign load_val  = load_sign ? (~binary + BIN_W'(1)) : binary;
`else
  assign load_val  = binary;
`endif

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state     <= IDLE;
      sreg      <= '0;
      acc       <= '0;
      cnt       <= '0;
      bcd       <= '0;
      out_valid <= 1'b0;
`ifdef BIN2BCD_SIGNED_EN
      sign_q    <= 1'b0;
      sign      <= 1'b0;
`endif
    end else if (en) begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sreg  <= load_val;
            acc   <= '0;
            cnt   <= CNT_W'(BIN_W);
            state <= SHIFT;
`ifdef BIN2BCD_SIGNED_EN
            sign_q <= load_sign;
`endif
          end
        end
        SHIFT: begin
          {acc, sreg} <= shifted;
          cnt         <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            bcd       <= shifted[ACC_W+BIN_W-1 -: ACC_W];
            out_valid <= 1'b1;
            state     <= DONE;
`ifdef BIN2BCD_SIGNED_EN
            sign      <= sign_q;
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
